// File: rtl/gpio_serial_loader.sv
// Streams per-pad configuration words into the housekeeping serial chains,
// with a registered bit-bang passthrough for software fallback.
module gpio_serial_loader #(
    parameter int NUM_CHAINS     = 2,
    parameter int PADS_PER_CHAIN = 19,
    parameter int CFG_BITS       = 13,
    parameter int CLK_DIV        = 4,
    localparam int AW = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rstn_i,
    input  logic                             xfer_start,
    input  logic                             xfer_abort,
    output logic                             xfer_busy,
    output logic                             xfer_done,
    output logic [AW-1:0]                    cfg_rd_addr,
    input  logic [NUM_CHAINS*CFG_BITS-1:0]   cfg_rd_data,
    input  logic                             bitbang_en,
    input  logic                             bitbang_clock,
    input  logic                             bitbang_load,
    input  logic                             bitbang_resetn,
    input  logic [NUM_CHAINS-1:0]            bitbang_data,
    output logic                             serial_clock,
    output logic                             serial_load,
    output logic                             serial_resetn,
    output logic [NUM_CHAINS-1:0]            serial_data,
    output logic [2:0]                       dbg_state
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(CFG_BITS + 1);
    localparam int WW = NUM_CHAINS * CFG_BITS;
    localparam logic [AW-1:0] LAST_ADDR = AW'(PADS_PER_CHAIN - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CFG_BITS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SHIFT_LO = 3'd2,
        SHIFT_HI = 3'd3,
        LOAD_HI  = 3'd4,
        LOAD_LO  = 3'd5,
        DONE     = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         div_q, div_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [WW-1:0]         shift_q, shift_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  sclk_q, sclk_d;
    logic                  sload_q, sload_d;
    logic                  srstn_q, srstn_d;
    logic [NUM_CHAINS-1:0] sdata_q, sdata_d;
    logic                  last_div;

    function automatic logic [NUM_CHAINS-1:0] chain_msbs(input logic [WW-1:0] w);
        logic [NUM_CHAINS-1:0] m;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            m[c] = w[c*CFG_BITS + CFG_BITS - 1];
        end
        return m;
    endfunction

    assign last_div = (div_q == DIV_LAST);

    // Handshake: xfer_start is accepted only in IDLE (without a same-cycle
    // abort); xfer_busy rises the next cycle and stays high through DONE.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        addr_d  = addr_q;
        shift_d = shift_q;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        sclk_d  = 1'b0;
        sload_d = 1'b0;
        srstn_d = 1'b1;
        sdata_d = sdata_q;
        case (state_q)
            IDLE: begin
                busy_d  = 1'b0;
                sdata_d = '0;
                if (xfer_start && !xfer_abort) begin
                    state_d = FETCH;
                    addr_d  = LAST_ADDR;
                    busy_d  = 1'b1;
                end else if (bitbang_en) begin
                    sclk_d  = bitbang_clock;
                    sload_d = bitbang_load;
                    srstn_d = bitbang_resetn;
                    sdata_d = bitbang_data;
                end
            end
            FETCH: begin
                shift_d = cfg_rd_data;
                sdata_d = chain_msbs(cfg_rd_data);
                div_d   = '0;
                bit_d   = '0;
                state_d = SHIFT_LO;
            end
            SHIFT_LO: begin
                if (last_div) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT_HI;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            SHIFT_HI: begin
                sclk_d = 1'b1;
                if (last_div) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (bit_q != BIT_LAST) begin
                        // A flat shift leaks each chain's MSB into the next
                        // chain's LSB, but that bit never reaches an MSB
                        // before the word is refetched.
                        bit_d   = bit_q + 1'b1;
                        shift_d = shift_q << 1;
                        sdata_d = chain_msbs(shift_q << 1);
                        state_d = SHIFT_LO;
                    end else if (addr_q != '0) begin
                        addr_d  = addr_q - 1'b1;
                        state_d = FETCH;
                    end else begin
                        sload_d = 1'b1;
                        state_d = LOAD_HI;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOAD_HI: begin
                sload_d = 1'b1;
                if (last_div) begin
                    div_d   = '0;
                    sload_d = 1'b0;
                    state_d = LOAD_LO;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            LOAD_LO: begin
                if (last_div) begin
                    div_d   = '0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase

        if (xfer_abort && state_q != IDLE && state_q != DONE) begin
            state_d = IDLE;
            addr_d  = '0;
            div_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            sclk_d  = 1'b0;
            sload_d = 1'b0;
            srstn_d = 1'b1;
            sdata_d = '0;
        end
    end

    // Reset holds the chains in reset (serial_resetn low) along with all else.
    always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
        if (!wb_rstn_i) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            addr_q  <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sload_q <= 1'b0;
            srstn_q <= 1'b0;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            addr_q  <= addr_d;
            shift_q <= shift_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sload_q <= sload_d;
            srstn_q <= srstn_d;
            sdata_q <= sdata_d;
        end
    end

    assign xfer_busy     = busy_q;
    assign xfer_done     = done_q;
    assign cfg_rd_addr   = addr_q;
    assign serial_clock  = sclk_q;
    assign serial_load   = sload_q;
    assign serial_resetn = srstn_q;
    assign serial_data   = sdata_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_gpio_serial_loader.sv
// Randomised and directed bench for gpio_serial_loader; a negedge monitor
// rebuilds the chain bitstream and compares it with a word-level model.
module tb_gpio_serial_loader;

    localparam int NC = 2, PP = 19, CB = 13, DV = 4;
    localparam int XFER_LEN = PP * (1 + 2 * DV * CB) + 2 * DV + 1;
    localparam int NEDGE = PP * CB;
    localparam int NC2 = 3, CB2 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // default-parameter instance
    logic rst_n, xfer_start, xfer_abort;
    logic bb_en, bb_clock, bb_load, bb_resetn;
    logic [NC-1:0] bb_data;
    logic xfer_busy, xfer_done, serial_clock, serial_load, serial_resetn;
    logic [NC-1:0] serial_data;
    logic [4:0] cfg_rd_addr;
    logic [NC*CB-1:0] cfg_rd_data;
    logic [2:0] dbg_state;
    logic [NC*CB-1:0] mem [PP];

    assign cfg_rd_data = mem[cfg_rd_addr];

    gpio_serial_loader dut (
        .wb_clk_i(clk), .wb_rstn_i(rst_n),
        .xfer_start(xfer_start), .xfer_abort(xfer_abort),
        .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .cfg_rd_addr(cfg_rd_addr), .cfg_rd_data(cfg_rd_data),
        .bitbang_en(bb_en), .bitbang_clock(bb_clock), .bitbang_load(bb_load),
        .bitbang_resetn(bb_resetn), .bitbang_data(bb_data),
        .serial_clock(serial_clock), .serial_load(serial_load),
        .serial_resetn(serial_resetn), .serial_data(serial_data),
        .dbg_state(dbg_state)
    );

    // corner-parameter instance
    logic rst2_n, start2, abort2;
    logic busy2, done2, sclk2, sload2, srstn2;
    logic [NC2-1:0] sdata2;
    logic [0:0] addr2;
    logic [NC2*CB2-1:0] cfg2;
    logic [2:0] dbg2;
    logic zero1 = 1'b0;
    logic [NC2-1:0] zero3 = '0;

    gpio_serial_loader #(.NUM_CHAINS(3), .PADS_PER_CHAIN(1), .CFG_BITS(4), .CLK_DIV(1)) dut2 (
        .wb_clk_i(clk), .wb_rstn_i(rst2_n),
        .xfer_start(start2), .xfer_abort(abort2),
        .xfer_busy(busy2), .xfer_done(done2),
        .cfg_rd_addr(addr2), .cfg_rd_data(cfg2),
        .bitbang_en(zero1), .bitbang_clock(zero1), .bitbang_load(zero1),
        .bitbang_resetn(zero1), .bitbang_data(zero3),
        .serial_clock(sclk2), .serial_load(sload2),
        .serial_resetn(srstn2), .serial_data(sdata2),
        .dbg_state(dbg2)
    );

    // monitor for the default instance, active only while busy
    int edges, done_cnt, busy_cnt, load_cycles, load_pulses, load_edge_at, unstable;
    logic mon_clr = 1'b0;
    logic prev_clk = 1'b0, prev_load = 1'b0;
    logic [NC-1:0] prev_data = '0, hi_data = '0;
    logic [NC-1:0] rx_q[$];

    always @(negedge clk) begin
        if (mon_clr) begin
            edges = 0; done_cnt = 0; busy_cnt = 0; load_cycles = 0;
            load_pulses = 0; load_edge_at = -1; unstable = 0;
            rx_q.delete();
        end else if (rst_n === 1'b1) begin
            if (xfer_busy === 1'b1) begin
                busy_cnt++;
                if (serial_clock && !prev_clk) begin
                    edges++;
                    rx_q.push_back(serial_data);
                    hi_data = serial_data;
                    if (serial_data !== prev_data) unstable++;
                end else if (serial_clock && serial_data !== hi_data) begin
                    unstable++;
                end
                if (serial_load) begin
                    load_cycles++;
                    if (serial_clock) unstable++;
                end
                if (serial_load && !prev_load) begin
                    load_pulses++;
                    load_edge_at = edges;
                end
            end
            if (xfer_done === 1'b1) done_cnt++;
        end
        prev_clk  = serial_clock;
        prev_load = serial_load;
        prev_data = serial_data;
    end

    // Reference: pads highest index first, each word MSB first, all chains in parallel.
    function automatic int stream_errors();
        logic [NC-1:0] exp_q[$];
        int errs = 0;
        for (int p = PP - 1; p >= 0; p--) begin
            for (int b = CB - 1; b >= 0; b--) begin
                logic [NC-1:0] v;
                for (int c = 0; c < NC; c++) v[c] = mem[p][c*CB + b];
                exp_q.push_back(v);
            end
        end
        if (rx_q.size() != exp_q.size()) return 1000 + rx_q.size();
        foreach (exp_q[i]) if (rx_q[i] !== exp_q[i]) errs++;
        return errs;
    endfunction

    // Word held at pad p of chain c by a 247-bit shift register fed from rx_q.
    function automatic logic [CB-1:0] chain_pad_word(input int c, input int p);
        logic [PP*CB-1:0] chain = '0;
        foreach (rx_q[i]) chain = {chain[PP*CB-2:0], rx_q[i][c]};
        return chain[p*CB +: CB];
    endfunction

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(negedge clk); #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 xfer_start = 1'b1;
        @(posedge clk); #1 xfer_start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < XFER_LEN + 100 && done_cnt == 0; i++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic randomize_mem();
        for (int p = 0; p < PP; p++) mem[p] = (NC*CB)'($urandom);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rst2_n = 1'b0;
        xfer_start = 0; xfer_abort = 0; start2 = 0; abort2 = 0;
        bb_en = 0; bb_clock = 0; bb_load = 0; bb_resetn = 0; bb_data = '0;
        cfg2 = '0;
        for (int p = 0; p < PP; p++) mem[p] = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1; rst2_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({serial_resetn, xfer_busy} !== 2'b10) $display("FAIL reset_release: resetn,busy got %b expected 10", {serial_resetn, xfer_busy}); else n_pass++;
        @(posedge clk); #3 rst_n = 1'b0; #1;
        n_checks++; if ({xfer_busy, xfer_done, serial_clock, serial_load, serial_resetn, serial_data, cfg_rd_addr} !== '0)
            $display("FAIL reset_async: outputs got %b expected all 0", {xfer_busy, xfer_done, serial_clock, serial_load, serial_resetn, serial_data, cfg_rd_addr}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({serial_resetn, xfer_busy, serial_clock} !== 3'b100) $display("FAIL reset_rerelease: resetn,busy,clock got %b expected 100", {serial_resetn, xfer_busy, serial_clock}); else n_pass++;
    endtask

    task automatic test_full_transfer();
        for (int p = 0; p < PP; p++) mem[p] = (p == 0) ? {13'h1809, 13'h1809} : {13'h0403, 13'h0403};
        clear_mon();
        pulse_start();
        #1;
        n_checks++; if ({xfer_busy, cfg_rd_addr} !== {1'b1, 5'd18}) $display("FAIL full_start: busy,addr got %b expected 1_10010", {xfer_busy, cfg_rd_addr}); else n_pass++;
        wait_done();
        n_checks++; if (edges !== NEDGE) $display("FAIL full_edges: got %0d expected %0d", edges, NEDGE); else n_pass++;
        n_checks++; if (busy_cnt !== XFER_LEN) $display("FAIL full_busy_len: got %0d expected %0d", busy_cnt, XFER_LEN); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL full_done: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (unstable !== 0) $display("FAIL full_data_stable: got %0d violations expected 0", unstable); else n_pass++;
        n_checks++; if ({load_pulses, load_cycles} !== {32'd1, 32'd4}) $display("FAIL full_load: pulses %0d cycles %0d expected 1 and 4", load_pulses, load_cycles); else n_pass++;
        n_checks++; if (load_edge_at !== NEDGE) $display("FAIL full_load_after_last_edge: got %0d expected %0d", load_edge_at, NEDGE); else n_pass++;
        n_checks++; if (stream_errors() !== 0) $display("FAIL full_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
        for (int c = 0; c < NC; c++) begin
            n_checks++; if (chain_pad_word(c, 0) !== 13'h1809) $display("FAIL full_pad0_chain%0d: got %h expected 1809", c, chain_pad_word(c, 0)); else n_pass++;
            n_checks++; if (chain_pad_word(c, 18) !== 13'h0403) $display("FAIL full_pad18_chain%0d: got %h expected 0403", c, chain_pad_word(c, 18)); else n_pass++;
        end
        n_checks++; if ({xfer_busy, serial_clock, serial_load} !== 3'b000) $display("FAIL full_idle_after: busy,clock,load got %b expected 000", {xfer_busy, serial_clock, serial_load}); else n_pass++;
    endtask

    task automatic test_restart_ignored();
        randomize_mem();
        clear_mon();
        pulse_start();
        repeat (498) @(posedge clk);
        #1 xfer_start = 1'b1;
        @(posedge clk); #1 xfer_start = 1'b0;
        wait_done();
        n_checks++; if (edges !== NEDGE) $display("FAIL restart_edges: got %0d expected %0d", edges, NEDGE); else n_pass++;
        n_checks++; if (busy_cnt !== XFER_LEN) $display("FAIL restart_busy_len: got %0d expected %0d", busy_cnt, XFER_LEN); else n_pass++;
        n_checks++; if (done_cnt !== 1) $display("FAIL restart_done: got %0d expected 1", done_cnt); else n_pass++;
        n_checks++; if (stream_errors() !== 0) $display("FAIL restart_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
    endtask

    task automatic test_abort();
        randomize_mem();
        clear_mon();
        pulse_start();
        for (int i = 0; i < XFER_LEN && edges < 50; i++) begin
            @(negedge clk); #1;
        end
        n_checks++; if (edges !== 50) $display("FAIL abort_reach_edge50: got %0d expected 50", edges); else n_pass++;
        @(posedge clk); #1 xfer_abort = 1'b1;
        @(posedge clk); #1 xfer_abort = 1'b0;
        n_checks++; if ({serial_clock, serial_load, xfer_busy} !== 3'b000) $display("FAIL abort_outputs: clock,load,busy got %b expected 000", {serial_clock, serial_load, xfer_busy}); else n_pass++;
        repeat (20) @(negedge clk);
        #1;
        n_checks++; if ({done_cnt, load_pulses, edges} !== {32'd0, 32'd0, 32'd50}) $display("FAIL abort_quiet: done %0d load %0d edges %0d expected 0 0 50", done_cnt, load_pulses, edges); else n_pass++;
        @(posedge clk); #1 xfer_start = 1'b1; xfer_abort = 1'b1;
        @(posedge clk); #1 xfer_start = 1'b0; xfer_abort = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (xfer_busy !== 1'b0) $display("FAIL abort_with_start_idle: busy got %b expected 0", xfer_busy); else n_pass++;
        randomize_mem();
        clear_mon();
        pulse_start();
        wait_done();
        n_checks++; if (busy_cnt !== XFER_LEN) $display("FAIL abort_next_busy_len: got %0d expected %0d", busy_cnt, XFER_LEN); else n_pass++;
        n_checks++; if ({edges, done_cnt} !== {NEDGE, 32'd1}) $display("FAIL abort_next_edges_done: edges %0d done %0d expected %0d 1", edges, done_cnt, NEDGE); else n_pass++;
        n_checks++; if (stream_errors() !== 0) $display("FAIL abort_next_stream: got %0d errors expected 0", stream_errors()); else n_pass++;
    endtask

    task automatic test_bitbang();
        logic [4:0] steps[$];
        logic [12:0] word = 13'h1809;
        logic [4:0] prev_v = 5'b00100;
        logic [4:0] obs;
        for (int b = 12; b >= 0; b--) begin
            steps.push_back({1'b0, 1'b0, 1'b1, {2{word[b]}}});
            steps.push_back({1'b1, 1'b0, 1'b1, {2{word[b]}}});
        end
        steps.push_back(5'b01100);
        steps.push_back(5'b00100);
        steps.push_back(5'b00000);
        steps.push_back(5'b00111);
        foreach (steps[i]) begin
            @(posedge clk); #1;
            bb_en = 1'b1;
            {bb_clock, bb_load, bb_resetn, bb_data} = steps[i];
            #2 obs = {serial_clock, serial_load, serial_resetn, serial_data};
            n_checks++; if (obs !== prev_v) $display("FAIL bitbang_latency_step%0d: got %b expected %b", i, obs, prev_v); else n_pass++;
            @(posedge clk); #1 obs = {serial_clock, serial_load, serial_resetn, serial_data};
            n_checks++; if (obs !== steps[i]) $display("FAIL bitbang_mirror_step%0d: got %b expected %b", i, obs, steps[i]); else n_pass++;
            prev_v = steps[i];
        end
        randomize_mem();
        clear_mon();
        pulse_start();
        for (int i = 0; i < XFER_LEN + 100 && done_cnt == 0; i++) begin
            @(negedge clk);
            {bb_clock, bb_load, bb_resetn, bb_data} = 5'($urandom);
            #1;
        end
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (busy_cnt !== XFER_LEN) $display("FAIL bitbang_takeover_busy_len: got %0d expected %0d", busy_cnt, XFER_LEN); else n_pass++;
        n_checks++; if ({load_pulses, load_cycles, done_cnt} !== {32'd1, 32'd4, 32'd1}) $display("FAIL bitbang_takeover_load_done: load %0d cycles %0d done %0d expected 1 4 1", load_pulses, load_cycles, done_cnt); else n_pass++;
        n_checks++; if (stream_errors() !== 0 || unstable !== 0) $display("FAIL bitbang_takeover_stream: got %0d errors %0d unstable expected 0 0", stream_errors(), unstable); else n_pass++;
        @(posedge clk); #1 {bb_clock, bb_load, bb_resetn, bb_data} = 5'b11010;
        @(posedge clk); #1 obs = {serial_clock, serial_load, serial_resetn, serial_data};
        n_checks++; if (obs !== 5'b11010) $display("FAIL bitbang_resume: got %b expected 11010", obs); else n_pass++;
        bb_en = 1'b0;
        @(posedge clk); #1 obs = {serial_clock, serial_load, serial_resetn, serial_data};
        n_checks++; if (obs !== 5'b00100) $display("FAIL bitbang_disabled_idle: got %b expected 00100", obs); else n_pass++;
    endtask

    task automatic test_corner();
        logic [NC2-1:0] rx[$];
        logic [CB2-1:0] w;
        int e2 = 0, b2 = 0, d2 = 0;
        logic pc = 1'b0;
        bit found = 0;
        cfg2 = (NC2*CB2)'($urandom);
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy2 === 1'b1) b2++;
            if (done2 === 1'b1) d2++;
            if (sclk2 && !pc) begin
                e2++;
                rx.push_back(sdata2);
            end
            pc = sclk2;
        end
        n_checks++; if (e2 !== 4) $display("FAIL corner_edges: got %0d expected 4", e2); else n_pass++;
        n_checks++; if (b2 !== 12) $display("FAIL corner_busy_len: got %0d expected 12", b2); else n_pass++;
        n_checks++; if ({d2, 31'd0, addr2} !== {32'd1, 32'd0}) $display("FAIL corner_done_addr: done %0d addr %0d expected 1 0", d2, addr2); else n_pass++;
        for (int c = 0; c < NC2; c++) begin
            w = 'x;
            for (int k = 0; k < rx.size() && k < CB2; k++) w = {w[CB2-2:0], rx[k][c]};
            n_checks++; if (w !== cfg2[c*CB2 +: CB2]) $display("FAIL corner_word_chain%0d: got %h expected %h", c, w, cfg2[c*CB2 +: CB2]); else n_pass++;
        end
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (sclk2 === 1'b1) found = 1;
        end
        n_checks++; if (found !== 1'b1) $display("FAIL corner_reach_shift_hi: got %0d expected 1", found); else n_pass++;
        #2 rst2_n = 1'b0;
        #1;
        n_checks++; if ({busy2, done2, sclk2, sload2, srstn2, sdata2, addr2} !== '0)
            $display("FAIL corner_async_reset: outputs got %b expected all 0", {busy2, done2, sclk2, sload2, srstn2, sdata2, addr2}); else n_pass++;
        @(negedge clk); rst2_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if ({srstn2, busy2} !== 2'b10) $display("FAIL corner_reset_release: resetn,busy got %b expected 10", {srstn2, busy2}); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_transfer();
        test_restart_ignored();
        test_abort();
        test_bitbang();
        test_corner();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
